window_3x3_gen: RTL

WINDOW_3X3_GEN -- requirements
Module: window_3x3_gen

---
 rtl/img_pkg.sv | 41 ++++
 rtl/line_buffer.sv | 27 ++
 rtl/window_3x3_gen.sv | 185 ++++++++++++++++++
 3 files changed

// File: rtl/img_pkg.sv
// Shared image-processing types: pixel and 3x3 window layout used by both the
// window generator and the downstream smoothening stage, plus the generator's
// FSM encodings and the window shift helper.
package img_pkg;

    localparam int PIX_W = 8;
    localparam int WIN_N = 9;

    typedef logic [PIX_W-1:0] pixel_t;

    // Index 0 is top-left, index 8 is bottom-right, row-major.
    typedef pixel_t [0:WIN_N-1] window_t;

    // Window generator FSM encodings.
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_FILL = 2'd1;
    localparam logic [1:0] ST_RUN  = 2'd2;
    localparam logic [1:0] ST_DONE = 2'd3;

    // Shift the window one column left and insert a new right-hand column
    // (top from the oldest line, bottom from the incoming pixel).
    function automatic window_t shift_window(
        input window_t w,
        input pixel_t  top,
        input pixel_t  mid,
        input pixel_t  bot
    );
        window_t r;
        r[0] = w[1];
        r[1] = w[2];
        r[2] = top;
        r[3] = w[4];
        r[4] = w[5];
        r[5] = mid;
        r[6] = w[7];
        r[7] = w[8];
        r[8] = bot;
        return r;
    endfunction

endpackage

// File: rtl/line_buffer.sv
// One image row of pixel storage. Read is asynchronous from the same address
// that is written, so a read-then-overwrite happens in a single accepted cycle.
module line_buffer
    import img_pkg::*;
#(
    parameter int DEPTH = 64,
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic          clk,
    input  logic          wr_en,
    input  logic [AW-1:0] addr,
    input  pixel_t        wr_data,
    output pixel_t        rd_data
);

    pixel_t mem_r [0:DEPTH-1];

    // Store the incoming pixel at the current column; contents are never reset.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_r[addr] <= wr_data;
        end
    end

    assign rd_data = mem_r[addr];

endmodule

// File: rtl/window_3x3_gen.sv
// Builds 3x3 neighbourhood windows from a raster pixel stream. Two line
// buffers hold the previous two rows; a 3x3 register array shifts one column
// per accepted pixel. Windows are emitted only for interior centres.
module window_3x3_gen
    import img_pkg::*;
#(
    parameter int IMG_W = 64,
    parameter int IMG_H = 128
) (
    input  logic    clk,
    input  logic    reset,
    input  pixel_t  pix_in,
    input  logic    pix_valid,
    input  logic    stall,
    output logic    pix_ready,
    output window_t win_out,
    output logic    win_valid,
    output logic    frame_done
);

    localparam int CW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam int RW = (IMG_H > 1) ? $clog2(IMG_H) : 1;

    localparam logic [CW-1:0] COL_ZERO = {CW{1'b0}};
    localparam logic [CW-1:0] COL_ONE  = CW'(1);
    localparam logic [CW-1:0] COL_TWO  = CW'(2);
    localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
    localparam logic [RW-1:0] ROW_ZERO = {RW{1'b0}};
    localparam logic [RW-1:0] ROW_ONE  = RW'(1);
    localparam logic [RW-1:0] ROW_TWO  = RW'(2);
    localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);

    logic          accept_s;
    logic          col_last_s;
    logic          row_last_s;
    logic          interior_s;
    logic [CW-1:0] col_r;
    logic [RW-1:0] row_r;
    logic [CW-1:0] col_next_s;
    logic [RW-1:0] row_next_s;
    logic [1:0]    state_r;
    logic [1:0]    state_next_s;
    pixel_t        lb1_rd_s;
    pixel_t        lb2_rd_s;
    window_t       win_r;
    window_t       win_shift_s;
    window_t       win_out_r;
    logic          win_valid_r;
    logic          frame_done_r;

    // Backpressure is passed straight through: nothing is taken while stalled.
    assign pix_ready  = ~stall;
    assign accept_s   = pix_valid & ~stall;
    assign col_last_s = (col_r == COL_LAST);
    assign row_last_s = (row_r == ROW_LAST);
    assign interior_s = accept_s & (row_r >= ROW_TWO) & (col_r >= COL_TWO);

    // lb1 holds row r-1; its old content cascades into lb2 (row r-2).
    line_buffer #(.DEPTH(IMG_W)) u_lb1 (
        .clk     (clk),
        .wr_en   (accept_s),
        .addr    (col_r),
        .wr_data (pix_in),
        .rd_data (lb1_rd_s)
    );

    line_buffer #(.DEPTH(IMG_W)) u_lb2 (
        .clk     (clk),
        .wr_en   (accept_s),
        .addr    (col_r),
        .wr_data (lb1_rd_s),
        .rd_data (lb2_rd_s)
    );

    assign win_shift_s = shift_window(win_r, lb2_rd_s, lb1_rd_s, pix_in);

    // Next raster position: column wraps into the next row, last pixel wraps to origin.
    always_comb begin
        col_next_s = col_r;
        row_next_s = row_r;
        if (accept_s) begin
            if (col_last_s) begin
                col_next_s = COL_ZERO;
                if (row_last_s) begin
                    row_next_s = ROW_ZERO;
                end else begin
                    row_next_s = row_r + ROW_ONE;
                end
            end else begin
                col_next_s = col_r + COL_ONE;
                row_next_s = row_r;
            end
        end else begin
            col_next_s = col_r;
            row_next_s = row_r;
        end
    end

    // Frame sequencing; a pixel taken in DONE is already at the origin and starts a new fill.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (accept_s) begin
                    state_next_s = ST_FILL;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_FILL: begin
                if (accept_s && (row_r == ROW_TWO) && (col_r == COL_ZERO)) begin
                    state_next_s = ST_RUN;
                end else begin
                    state_next_s = ST_FILL;
                end
            end
            ST_RUN: begin
                if (accept_s && row_last_s && col_last_s) begin
                    state_next_s = ST_DONE;
                end else begin
                    state_next_s = ST_RUN;
                end
            end
            ST_DONE: begin
                if (accept_s) begin
                    state_next_s = ST_FILL;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            default: begin
                state_next_s = ST_IDLE;
            end
        endcase
    end

    // Raster position counters, frozen while stalled.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            col_r <= COL_ZERO;
            row_r <= ROW_ZERO;
        end else if (!stall) begin
            col_r <= col_next_s;
            row_r <= row_next_s;
        end
    end

    // FSM state and the frame_done pulse that marks the DONE cycle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r      <= ST_IDLE;
            frame_done_r <= 1'b0;
        end else if (!stall) begin
            state_r      <= state_next_s;
            frame_done_r <= (state_next_s == ST_DONE);
        end
    end

    // 3x3 shift array, advanced by one column per accepted pixel.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            win_r <= '{default: 8'd0};
        end else if (accept_s) begin
            win_r <= win_shift_s;
        end
    end

    // Output window register: loaded only for interior centres, valid for one cycle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            win_out_r   <= '{default: 8'd0};
            win_valid_r <= 1'b0;
        end else if (!stall) begin
            win_valid_r <= interior_s;
            if (interior_s) begin
                win_out_r <= win_shift_s;
            end
        end
    end

    assign win_out    = win_out_r;
    assign win_valid  = win_valid_r;
    assign frame_done = frame_done_r;

endmodule
